compute_dispatch_core: RTL

COMPUTE_DISPATCH_CORE -- requirements
Module: compute_dispatch_core

---
 rtl/compute_dispatch_core.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/compute_dispatch_core.sv
// compute_dispatch_core
//
// Purpose:
// The host queues commands. This block pops them one at a time, decodes the opcode and
// starts one of NUM_ENG engines. While that engine runs, it owns the memory ports, and
// its addresses are relocated by the command's operand bases. When no engine is active,
// the host owns the memory. Host writes reach memory only while the dispatcher is idle
// and the queue is empty.
//
// Command word layout: {OP3, OP2, OP1, INS}, with INS in the LSBs.
//   INS == 0                      : NOP, retired without starting an engine
//   INS == OPBASE + k, k<NUM_ENG  : start engine k
//   any other INS                 : illegal, sets err_illegal and retires
//
// Ports:
//   clk, rst_n                       clock and synchronous active-low reset
//   cmd_in/cmd_valid/cmd_ready       command queue push interface
//   host_addr/host_din/host_we       host memory access
//   host_dout                        host read data (mem_doutb)
//   mem_addra/mem_wea/mem_dina       memory write port
//   mem_addrb/mem_doutb              memory read port (1-cycle latency)
//   eng_start/eng_active/eng_op2     engine control
//   eng_rd_addr/eng_wt_addr/eng_we/eng_op2_sel/eng_done/eng_dout
//                                    per-engine requests, packed with engine 0 in the LSBs
//   busy/done_pulse                  status
//   err_illegal/err_timeout          sticky error flags
//   fifo_count                       queue occupancy
module compute_dispatch_core #(
  parameter int unsigned ADDRW      = 10,
  parameter int unsigned DATAW      = 64,
  parameter int unsigned INSW       = 5,
  parameter int unsigned NUM_ENG    = 4,
  parameter int unsigned OPBASE     = 21,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [INSW+3*ADDRW-1:0]       cmd_in,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ADDRW-1:0]              host_addr,
  input  logic [DATAW-1:0]              host_din,
  input  logic                          host_we,
  output logic [DATAW-1:0]              host_dout,
  output logic [ADDRW-1:0]              mem_addra,
  output logic                          mem_wea,
  output logic [DATAW-1:0]              mem_dina,
  output logic [ADDRW-1:0]              mem_addrb,
  input  logic [DATAW-1:0]              mem_doutb,
  output logic [NUM_ENG-1:0]            eng_start,
  output logic [NUM_ENG-1:0]            eng_active,
  output logic [ADDRW-1:0]              eng_op2,
  input  logic [NUM_ENG*ADDRW-1:0]      eng_rd_addr,
  input  logic [NUM_ENG*ADDRW-1:0]      eng_wt_addr,
  input  logic [NUM_ENG-1:0]            eng_we,
  input  logic [NUM_ENG-1:0]            eng_op2_sel,
  input  logic [NUM_ENG-1:0]            eng_done,
  input  logic [NUM_ENG*DATAW-1:0]      eng_dout,
  output logic                          busy,
  output logic                          done_pulse,
  output logic                          err_illegal,
  output logic                          err_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CMDW  = INSW + 3 * ADDRW;
  localparam int unsigned PTRW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SLOTS = 1 << PTRW;
  localparam int unsigned EIW   = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StRun, StRetire} state_e;

  state_e state_q, state_d;

  // Command queue
  logic [CMDW-1:0] fifo_q [SLOTS];
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            push, pop;

  // Current command and its decode
  logic [CMDW-1:0]    cmd_q;
  logic [INSW-1:0]    ins;
  logic [ADDRW-1:0]   op1, op2, op3;
  logic               is_nop, is_eng;
  logic [EIW-1:0]     eng_idx;
  logic [NUM_ENG-1:0] sel_oh;
  logic               done_sel;

  // Watchdog
  logic [15:0] cnt_q;
  logic        timeout_hit;

  logic err_illegal_q, err_timeout_q;

  // ---------------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------------
  // cmd_ready depends only on the registered occupancy. A full queue therefore refuses a
  // push even on a cycle where it is also being popped.
  assign cmd_ready  = (count_q != CNTW'(FIFO_DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign pop        = (state_q == StIdle) && (count_q != '0);
  assign fifo_count = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue storage has no reset; the pointers and the count define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= cmd_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode of the current command
  // ---------------------------------------------------------------------------
  assign ins = cmd_q[INSW-1:0];
  assign op1 = cmd_q[INSW +: ADDRW];
  assign op2 = cmd_q[INSW+ADDRW +: ADDRW];
  assign op3 = cmd_q[INSW+2*ADDRW +: ADDRW];

  always_comb begin
    int unsigned ins_u;
    ins_u   = 32'(ins);
    is_nop  = (ins == '0);
    is_eng  = !is_nop && (ins_u >= OPBASE) && (ins_u < OPBASE + NUM_ENG);
    eng_idx = EIW'(ins_u - OPBASE);
    sel_oh  = is_eng ? (NUM_ENG'(1) << eng_idx) : '0;
  end

  // Only the selected engine can end RUN; done from any other engine is masked here.
  assign done_sel = |(eng_done & sel_oh);

  // The counter holds the number of RUN cycles already completed, so the hit fires on the
  // TIMEOUT-th RUN cycle.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (count_q != '0) state_d = StIssue;
      StIssue:  state_d = is_eng ? StRun : StRetire;
      StRun:    if (done_sel || timeout_hit) state_d = StRetire;
      StRetire: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // eng_active is already high in ISSUE, so the engine leaves reset in the same cycle
  // that it sees its start pulse.
  always_comb begin
    eng_start  = '0;
    eng_active = '0;
    done_pulse = 1'b0;
    busy       = (state_q != StIdle) || (count_q != '0);
    case (state_q)
      StIssue: begin
        eng_start  = sel_oh;
        eng_active = sel_oh;
      end
      StRun:    eng_active = sel_oh;
      StRetire: done_pulse = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cmd_q         <= '0;
      cnt_q         <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTRW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTRW'(1);
        cmd_q    <= fifo_q[rd_ptr_q];
      end
      if (state_q == StIssue) begin
        cnt_q <= '0;
      end else if (state_q == StRun) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if ((state_q == StIssue) && !is_nop && !is_eng) begin
        err_illegal_q <= 1'b1;
      end
      // A done that arrives on the last allowed cycle still wins over the watchdog.
      if ((state_q == StRun) && timeout_hit && !done_sel) begin
        err_timeout_q <= 1'b1;
      end
    end
  end

  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
  assign eng_op2     = op2;
  assign host_dout   = mem_doutb;

  // ---------------------------------------------------------------------------
  // Memory port steering
  // ---------------------------------------------------------------------------
  // The ADDRW-bit sums wrap modulo 2^ADDRW.
  always_comb begin
    int unsigned abase;
    int unsigned dbase;
    abase     = 32'(eng_idx) * ADDRW;
    dbase     = 32'(eng_idx) * DATAW;
    mem_addra = host_addr;
    mem_addrb = host_addr;
    mem_dina  = host_din;
    mem_wea   = host_we && (state_q == StIdle) && (count_q == '0);
    if (eng_active != '0) begin
      mem_addra = op3 + eng_wt_addr[abase +: ADDRW];
      mem_addrb = (eng_op2_sel[eng_idx] ? op2 : op1) + eng_rd_addr[abase +: ADDRW];
      mem_wea   = eng_we[eng_idx];
      mem_dina  = eng_dout[dbase +: DATAW];
    end
  end

endmodule
